// File: rtl/quant_table_loader.sv
// Writable 8x64-bit quantisation table: byte-serial valid/ready load port and a
// registered byte-addressed read port with the same row/byte mapping as the fixed table.
module quant_table_loader #(
  parameter int DATA_W    = 8,
  parameter int NUM_BYTES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              busy,
  output logic              load_done,
  output logic              tbl_valid,
  input  logic [5:0]        a,
  output logic [DATA_W-1:0] d
);

  localparam int ROWS  = NUM_BYTES / 8;
  localparam int ROW_W = 8 * DATA_W;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOAD = 1'b1;

  logic [0:0]        r_state;
  logic [5:0]        r_ptr;
  logic [ROW_W-1:0]  r_tbl [ROWS];
  logic [DATA_W-1:0] r_d;
  logic              r_done;
  logic              r_tbl_valid;

  logic              w_loading;
  logic              w_accept;
  logic              w_last;

  assign w_loading = (r_state == S_LOAD);
  assign w_accept  = w_loading && wr_valid;
  assign w_last    = (r_ptr == 6'(NUM_BYTES - 1));

  assign wr_ready  = w_loading;
  assign busy      = w_loading;
  assign load_done = r_done;
  assign tbl_valid = r_tbl_valid;
  assign d         = r_d;

  // Byte 0 of a row sits in the top byte lane, so the lane base is (7 - pos) * 8.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= 6'd0;
      r_d         <= '0;
      r_done      <= 1'b0;
      r_tbl_valid <= 1'b0;
      for (int i = 0; i < ROWS; i++) begin
        r_tbl[i] <= '0;
      end
    end else begin
      r_d    <= r_tbl[a[5:3]][{~a[2:0], 3'b000} +: DATA_W];
      r_done <= 1'b0;

      if (w_accept) begin
        r_tbl[r_ptr[5:3]][{~r_ptr[2:0], 3'b000} +: DATA_W] <= wr_data;
        r_ptr <= r_ptr + 6'd1;
        if (w_last && !load_start) begin
          r_state     <= S_IDLE;
          r_done      <= 1'b1;
          r_tbl_valid <= 1'b1;
        end
      end

      // A restart overrides any pointer advance or completion from the same edge.
      if (load_start) begin
        r_state     <= S_LOAD;
        r_ptr       <= 6'd0;
        r_tbl_valid <= 1'b0;
      end
    end
  end

endmodule
